// File: rtl/godai_trace_buffer.sv
// Trace capture unit for the Godai core: timestamps per-cycle core events and
// queues one record per active cycle in a first-word-fall-through FIFO drained over valid/ready.
module godai_trace_buffer #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          TS_WIDTH   = 16,
  parameter int          DEPTH      = 16,
  parameter int          DROP_WIDTH = 8,
  parameter logic [4:0]  EVENT_MASK = 5'b11111
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable_i,
  input  logic                              is_decoding_i,
  input  logic                              jump_done_i,
  input  logic                              branch_valid_i,
  input  logic                              branch_decision_i,
  input  logic [ADDR_WIDTH-1:0]             pc_i,
  input  logic                              data_req_i,
  input  logic                              data_gnt_i,
  input  logic                              data_we_i,
  input  logic [ADDR_WIDTH-1:0]             data_addr_i,
  output logic                              trace_valid_o,
  input  logic                              trace_ready_i,
  output logic [TS_WIDTH+9+2*ADDR_WIDTH-1:0] trace_data_o,
  output logic [$clog2(DEPTH):0]            level_o,
  output logic [DROP_WIDTH-1:0]             dropped_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int REC_W = TS_WIDTH + 9 + 2 * ADDR_WIDTH;

  // Stream handshake: a record transfers on every edge where trace_valid_o and
  // trace_ready_i are both high; while valid is high and ready low, trace_data_o
  // holds stable and valid never drops except through reset.

  logic [TS_WIDTH-1:0] ts;
  logic                ts_wrap;
  logic                pend_wrap;
  logic                pend_ovf;
  logic [PW:0]         wr_ptr;
  logic [PW:0]         rd_ptr;
  logic [REC_W-1:0]    mem [DEPTH];

  logic ev_decode, ev_jump, ev_branch, ev_taken, ev_load, ev_store;
  logic capture, full, empty, push, pop, drop;
  logic [REC_W-1:0] rec;

  assign ev_decode = is_decoding_i & EVENT_MASK[0];
  assign ev_jump   = jump_done_i & EVENT_MASK[1];
  assign ev_branch = branch_valid_i & EVENT_MASK[2];
  assign ev_taken  = branch_valid_i & branch_decision_i & EVENT_MASK[2];
  assign ev_load   = data_req_i & data_gnt_i & ~data_we_i & EVENT_MASK[3];
  assign ev_store  = data_req_i & data_gnt_i & data_we_i & EVENT_MASK[4];

  assign capture = enable_i & (ev_decode | ev_jump | ev_branch | ev_load | ev_store);
  assign ts_wrap = &ts;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = trace_valid_o & trace_ready_i;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push  = capture & (~full | pop);
  assign drop  = capture & full & ~pop;

  // A wrap landing on the same edge as a write is reported in that record.
  assign rec = {ts, pend_wrap | ts_wrap, 1'b0, pend_ovf,
                ev_taken, ev_store, ev_load, ev_branch, ev_jump, ev_decode,
                (ev_load | ev_store) ? data_addr_i : {ADDR_WIDTH{1'b0}},
                ev_decode ? pc_i : {ADDR_WIDTH{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts        <= '0;
      pend_wrap <= 1'b0;
      pend_ovf  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dropped_o <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (push) begin
        pend_wrap <= 1'b0;
        pend_ovf  <= 1'b0;
        wr_ptr    <= wr_ptr + 1'b1;
      end else begin
        if (ts_wrap) pend_wrap <= 1'b1;
        if (drop)    pend_ovf  <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && !(&dropped_o)) dropped_o <= dropped_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= rec;
  end

  assign trace_valid_o = ~empty;
  assign trace_data_o  = empty ? {REC_W{1'b0}} : mem[rd_ptr[PW-1:0]];
  assign level_o       = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_godai_trace_buffer.sv
// Directed bench for godai_trace_buffer: a small-depth, short-timestamp instance plus a
// decode-only masked instance sharing the same stimulus.
module tb_godai_trace_buffer;
  localparam int AW = 32;
  localparam int TW = 4;
  localparam int RW = TW + 9 + 2 * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic          is_decoding_i = 1'b0;
  logic          jump_done_i = 1'b0;
  logic          branch_valid_i = 1'b0;
  logic          branch_decision_i = 1'b0;
  logic [AW-1:0] pc_i = '0;
  logic          data_req_i = 1'b0;
  logic          data_gnt_i = 1'b0;
  logic          data_we_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic          trace_ready_i = 1'b0;

  logic          valid_a, valid_m;
  logic [RW-1:0] data_a, data_m;
  logic [2:0]    level_a, level_m;
  logic [1:0]    dropped_a, dropped_m;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] F_DEC  = 6'b000001; // {taken,store,load,branch,jump,decode}
  localparam logic [5:0] F_BRST = 6'b110100;
  localparam logic [5:0] F_LOAD = 6'b001000;

  always #5 clk = ~clk;

  godai_trace_buffer #(.ADDR_WIDTH(AW), .TS_WIDTH(TW), .DEPTH(4), .DROP_WIDTH(2),
                       .EVENT_MASK(5'b11111)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .is_decoding_i(is_decoding_i),
    .jump_done_i(jump_done_i), .branch_valid_i(branch_valid_i),
    .branch_decision_i(branch_decision_i), .pc_i(pc_i), .data_req_i(data_req_i),
    .data_gnt_i(data_gnt_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .trace_valid_o(valid_a), .trace_ready_i(trace_ready_i), .trace_data_o(data_a),
    .level_o(level_a), .dropped_o(dropped_a));

  godai_trace_buffer #(.ADDR_WIDTH(AW), .TS_WIDTH(TW), .DEPTH(4), .DROP_WIDTH(2),
                       .EVENT_MASK(5'b00001)) u_mask (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .is_decoding_i(is_decoding_i),
    .jump_done_i(jump_done_i), .branch_valid_i(branch_valid_i),
    .branch_decision_i(branch_decision_i), .pc_i(pc_i), .data_req_i(data_req_i),
    .data_gnt_i(data_gnt_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .trace_valid_o(valid_m), .trace_ready_i(trace_ready_i), .trace_data_o(data_m),
    .level_o(level_m), .dropped_o(dropped_m));

  function automatic logic [RW-1:0] mk(input logic [TW-1:0] ts, input logic wrap,
                                       input logic ovf, input logic [5:0] f,
                                       input logic [AW-1:0] daddr, input logic [AW-1:0] pc);
    return {ts, wrap, 1'b0, ovf, f, daddr, pc};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 3 time units after an edge, inside the cycle with ts=0.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    enable_i = 1'b0; is_decoding_i = 1'b0; jump_done_i = 1'b0;
    branch_valid_i = 1'b0; branch_decision_i = 1'b0; pc_i = '0;
    data_req_i = 1'b0; data_gnt_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0;
    trace_ready_i = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", 128'(valid_a), 128'(0));
    check("rst_level", 128'(level_a), 128'(0));
    check("rst_dropped", 128'(dropped_a), 128'(0));
    check("rst_data", 128'(data_a), 128'(0));

    // Decode at ts=5 with ready high: visible one cycle later, then popped
    repeat (5) step();
    enable_i = 1'b1; is_decoding_i = 1'b1; pc_i = 32'h20; trace_ready_i = 1'b1;
    step();
    is_decoding_i = 1'b0;
    check("dec_valid", 128'(valid_a), 128'(1));
    check("dec_data", 128'(data_a), 128'(mk(4'd5, 1'b0, 1'b0, F_DEC, 32'h0, 32'h20)));
    check("dec_level", 128'(level_a), 128'(1));
    step();
    check("dec_level_after_pop", 128'(level_a), 128'(0));
    check("dec_valid_after_pop", 128'(valid_a), 128'(0));

    // Branch taken plus store in one cycle, pc not in decode is zeroed
    do_reset();
    enable_i = 1'b1; branch_valid_i = 1'b1; branch_decision_i = 1'b1;
    data_req_i = 1'b1; data_gnt_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h1000;
    pc_i = 32'h55;
    step();
    branch_valid_i = 1'b0; branch_decision_i = 1'b0;
    data_req_i = 1'b0; data_gnt_i = 1'b0; data_we_i = 1'b0;
    check("brst_data", 128'(data_a), 128'(mk(4'd0, 1'b0, 1'b0, F_BRST, 32'h1000, 32'h0)));
    check("brst_level", 128'(level_a), 128'(1));
    check("brst_mask_level", 128'(level_m), 128'(0));

    // Overflow: six decodes into a depth-4 FIFO with ready low
    do_reset();
    enable_i = 1'b1; is_decoding_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc_i = 32'h100 + 32'(i);
      step();
    end
    is_decoding_i = 1'b0;
    check("ovf_level", 128'(level_a), 128'(4));
    check("ovf_dropped", 128'(dropped_a), 128'(2));
    trace_ready_i = 1'b1;
    check("ovf_drain0", 128'(data_a), 128'(mk(4'd0, 1'b0, 1'b0, F_DEC, 32'h0, 32'h100)));
    step();
    check("ovf_drain1", 128'(data_a), 128'(mk(4'd1, 1'b0, 1'b0, F_DEC, 32'h0, 32'h101)));
    step();
    check("ovf_drain2", 128'(data_a), 128'(mk(4'd2, 1'b0, 1'b0, F_DEC, 32'h0, 32'h102)));
    step();
    check("ovf_drain3", 128'(data_a), 128'(mk(4'd3, 1'b0, 1'b0, F_DEC, 32'h0, 32'h103)));
    step();
    check("ovf_empty", 128'(valid_a), 128'(0));
    // Now in cycle ts=10
    trace_ready_i = 1'b0; is_decoding_i = 1'b1; pc_i = 32'h200;
    step();
    pc_i = 32'h201;
    step();
    is_decoding_i = 1'b0;
    check("ovf_marked", 128'(data_a), 128'(mk(4'd10, 1'b0, 1'b1, F_DEC, 32'h0, 32'h200)));
    trace_ready_i = 1'b1;
    step();
    check("ovf_cleared", 128'(data_a), 128'(mk(4'd11, 1'b0, 1'b0, F_DEC, 32'h0, 32'h201)));
    check("ovf_dropped_hold", 128'(dropped_a), 128'(2));

    // Timestamp wrap: 20 idle cycles, then decode at ts=4
    do_reset();
    enable_i = 1'b1;
    repeat (20) step();
    is_decoding_i = 1'b1; pc_i = 32'h44;
    step();
    pc_i = 32'h45;
    step();
    is_decoding_i = 1'b0;
    check("wrap_marked", 128'(data_a), 128'(mk(4'd4, 1'b1, 1'b0, F_DEC, 32'h0, 32'h44)));
    trace_ready_i = 1'b1;
    step();
    check("wrap_cleared", 128'(data_a), 128'(mk(4'd5, 1'b0, 1'b0, F_DEC, 32'h0, 32'h45)));

    // Full with simultaneous pop and push, then saturating drops
    do_reset();
    enable_i = 1'b1; is_decoding_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'h300 + 32'(i);
      step();
    end
    check("full_level", 128'(level_a), 128'(4));
    trace_ready_i = 1'b1; pc_i = 32'h344;
    step();
    trace_ready_i = 1'b0;
    check("fullpop_level", 128'(level_a), 128'(4));
    check("fullpop_dropped", 128'(dropped_a), 128'(0));
    check("fullpop_head", 128'(data_a), 128'(mk(4'd1, 1'b0, 1'b0, F_DEC, 32'h0, 32'h301)));
    repeat (4) step();
    is_decoding_i = 1'b0;
    check("sat_dropped", 128'(dropped_a), 128'(3));
    check("sat_level", 128'(level_a), 128'(4));

    // Masked loads, disabled decodes, then async reset with level 3
    do_reset();
    enable_i = 1'b1; data_req_i = 1'b1; data_gnt_i = 1'b1; data_addr_i = 32'h80;
    repeat (3) step();
    data_req_i = 1'b0; data_gnt_i = 1'b0;
    check("mask_level", 128'(level_m), 128'(0));
    check("mask_valid", 128'(valid_m), 128'(0));
    check("load_level", 128'(level_a), 128'(3));
    check("load_data", 128'(data_a), 128'(mk(4'd0, 1'b0, 1'b0, F_LOAD, 32'h80, 32'h0)));
    enable_i = 1'b0; is_decoding_i = 1'b1; pc_i = 32'h90;
    repeat (3) step();
    check("dis_level", 128'(level_a), 128'(3));
    check("dis_mask_level", 128'(level_m), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 128'(valid_a), 128'(0));
    check("async_level", 128'(level_a), 128'(0));
    check("async_data", 128'(data_a), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
